ffinal: RTL and testbench
=========================

// Module: ffinal
// PURPOSE
// - Top-level free-running two-digit decimal counter (00..99) driving two 7-segment displays.
// - A prescaler sets the count rate. Each BCD digit is decoded to a 7-segment pattern on s.
// - The block is self-contained: its only inputs are clock and reset.
// PARAMETERS
// - TICK_DIV    default 1  clock cycles per count step; legal range >=1; 1 = step every cycle
// - ACTIVE_LOW  default 0  1 = invert all segment outputs (common-anode boards)
// PORTS
// - clk  input   1   system clock; everything is on the rising edge
// - rst  input   1   reset, synchronous, active-low (rst==0 at a rising clk edge resets)
// - s    output  14  segments: s[13:7] = tens digit, s[6:0] = ones digit
// -                  each digit is ordered {a,b,c,d,e,f,g}, with a at the MSB
// BEHAVIOUR
// - One clock domain. Reset is synchronous and active-low.
// - State registers:
//   - presc : width clog2(TICK_DIV), minimum 1 bit
//   - ones  : 4-bit BCD
//   - tens  : 4-bit BCD
// - Reset (rst==0 at posedge): presc=0, ones=0, tens=0.
//   - s then shows "00": 14'h3F7E, or 14'h0081 when ACTIVE_LOW=1.
// - Reset has priority over counting. It also applies mid-count and discards any partial prescale.
// - Prescaler:
//   - tick = (presc == TICK_DIV-1).
//   - On tick, presc returns to 0; otherwise presc increments by 1.
// - Count step on tick:
//   - ones<9: ones+1.
//   - ones==9: ones=0; then tens+1 if tens<9.
//   - At 99 the count wraps to 00 on the next tick. There is no carry-out and no overflow flag.
// - BCD values 10..15 are unreachable. The decoder maps them to all segments off (7'b0000000 before inversion).
// - s is a purely combinational decode of the ones/tens registers, with no extra pipeline stage.
//   - s changes in the same cycle the register updates.
//   - First step appears TICK_DIV clocks after reset is released.
// - Decode table, abcdefg:
//   - 0=1111110  1=0110000  2=1101101  3=1111001  4=0110011
//   - 5=1011011  6=1011111  7=1110000  8=1111111  9=1111011
// - ACTIVE_LOW=1: both digits are bitwise inverted after decode.
// - Before the first reset, register contents are undefined. Only values after reset are checked.
// STRUCTURE
// - Shared package ffinal_pkg holds:
//   - SEG_W=7, DIGIT_W=4
//   - the ten segment pattern constants SEG_0..SEG_9 and SEG_BLANK
// - Sub-module seg7_decode (4-bit BCD in, 7-bit abcdefg out, parameter ACTIVE_LOW) is instantiated twice.
// - Top level contains: the prescaler, the BCD counter chain, and two seg7_decode instances.
// TESTING
// - Reset: hold rst=0 for 1 clk, TICK_DIV=1 -> s==14'h3F7E; it holds while rst stays 0.
// - Single step: TICK_DIV=1, release rst -> s sequence:
//   - after 1 clk: 14'h3F30 ("01")
//   - after 10 clks: 14'h187E ("10")
// - Wrap: TICK_DIV=1 -> after 99 clks s==14'h3DFB ("99"); after the 100th clk s==14'h3F7E ("00").
// - Prescale: TICK_DIV=4 -> s stays 14'h3F7E for 3 clks and becomes 14'h3F30 on the 4th clk.
// - Mid-run reset: count to "37", assert rst=0 for 1 clk -> s==14'h3F7E. After release, counting resumes from "00" with a full prescale.
// - Polarity: ACTIVE_LOW=1 -> after reset s==14'h0081; after 1 step s==14'h00CF.

Source files
------------

// File: rtl/ffinal_pkg.sv
// Shared widths and 7-segment patterns for the two-digit decimal counter.
// Segment order is {a,b,c,d,e,f,g}, with a at the MSB, active-high.
package ffinal_pkg;

  localparam int SEG_W   = 7;
  localparam int DIGIT_W = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

endpackage : ffinal_pkg

// File: rtl/ffinal_seg7_decode.sv
// BCD digit to 7-segment decoder; codes 10..15 blank the digit.
// ACTIVE_LOW inverts the pattern for common-anode displays.
module seg7_decode
  import ffinal_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [DIGIT_W-1:0] bcd,
  output logic [SEG_W-1:0]   seg
);

  logic [SEG_W-1:0] seg_raw;

  // NOTE: seg_raw gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    seg_raw = SEG_BLANK;
    case (bcd)
      4'd0:    seg_raw = SEG_0;
      4'd1:    seg_raw = SEG_1;
      4'd2:    seg_raw = SEG_2;
      4'd3:    seg_raw = SEG_3;
      4'd4:    seg_raw = SEG_4;
      4'd5:    seg_raw = SEG_5;
      4'd6:    seg_raw = SEG_6;
      4'd7:    seg_raw = SEG_7;
      4'd8:    seg_raw = SEG_8;
      4'd9:    seg_raw = SEG_9;
      default: seg_raw = SEG_BLANK;
    endcase
  end

  assign seg = ACTIVE_LOW ? ~seg_raw : seg_raw;

endmodule : seg7_decode

// File: rtl/ffinal.sv
// Free-running 00..99 decimal counter with prescaler, driving two 7-segment digits.
// s[13:7] shows tens, s[6:0] shows ones; decode is combinational from the counter registers.
module ffinal
  import ffinal_pkg::*;
#(
  parameter int TICK_DIV   = 1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [13:0]   s
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]      presc;
  logic [DIGIT_W-1:0] ones;
  logic [DIGIT_W-1:0] tens;
  logic               tick;

  assign tick = (presc == PRESC_MAX);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc <= '0;
      ones  <= '0;
      tens  <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        if (ones == 4'd9) begin
          ones <= '0;
          tens <= (tens == 4'd9) ? '0 : tens + 4'd1;
        end else begin
          ones <= ones + 4'd1;
        end
      end
    end
  end

  seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_tens (
    .bcd (tens),
    .seg (s[13:7])
  );

  seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_ones (
    .bcd (ones),
    .seg (s[6:0])
  );

endmodule : ffinal

// File: tb/tb_ffinal.sv
// Bench for ffinal: three configurations share clk/rst; a cycle-count model predicts the display
// each cycle, and directed literal checks pin reset, first step, carry, wrap, prescale and polarity.
module tb_ffinal;

  logic        clk;
  logic        rst;
  logic [13:0] s1, s4, sal;

  int errors = 0;
  int checks = 0;

  ffinal #(.TICK_DIV(1), .ACTIVE_LOW(1'b0)) dut1  (.clk(clk), .rst(rst), .s(s1));
  ffinal #(.TICK_DIV(4), .ACTIVE_LOW(1'b0)) dut4  (.clk(clk), .rst(rst), .s(s4));
  ffinal #(.TICK_DIV(3), .ACTIVE_LOW(1'b1)) dutal (.clk(clk), .rst(rst), .s(sal));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the display value is simply (clocks since reset / TICK_DIV) mod 100.
  int  k = 0;
  bit  valid = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      k     <= 0;
      valid <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  function automatic logic [6:0] digit_pat(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    return tbl[d];
  endfunction

  function automatic logic [13:0] expect_s(input int cycles, input int div, input bit al);
    int          v;
    logic [13:0] r;
    v = (cycles / div) % 100;
    r = {digit_pat(v / 10), digit_pat(v % 10)};
    return al ? ~r : r;
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (valid) begin
      check("model_div1", s1,  expect_s(k, 1, 1'b0));
      check("model_div4", s4,  expect_s(k, 4, 1'b0));
      check("model_al3",  sal, expect_s(k, 3, 1'b1));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    cycles(1);
    check("reset_div1", s1,  14'h3F7E);
    check("reset_div4", s4,  14'h3F7E);
    check("reset_al",   sal, 14'h0081);
    cycles(1);
    check("reset_hold", s1,  14'h3F7E);

    rst = 1'b1;
    cycles(1);
    check("step1_div1", s1,  14'h3F30);
    check("step1_div4", s4,  14'h3F7E);
    check("step1_al",   sal, 14'h0081);
    cycles(2);
    check("presc3_div4", s4, 14'h3F7E);
    check("step_al",    sal, 14'h00CF);
    cycles(1);
    check("presc4_div4", s4, 14'h3F30);
    cycles(6);
    check("carry_10",   s1,  14'h187E);
    cycles(89);
    check("count_99",   s1,  14'h3DFB);
    cycles(1);
    check("wrap_00",    s1,  14'h3F7E);

    rst = 1'b0;
    cycles(1);
    rst = 1'b1;
    cycles(37);
    check("count_37",   s1,  14'h3CF0);
    rst = 1'b0;
    cycles(1);
    check("midreset_div1", s1, 14'h3F7E);
    check("midreset_div4", s4, 14'h3F7E);
    rst = 1'b1;
    cycles(1);
    check("resume_div1", s1, 14'h3F30);
    cycles(2);
    check("resume_div4_partial", s4, 14'h3F7E);
    cycles(1);
    check("resume_div4_full", s4, 14'h3F30);

    // Random run with occasional reset pulses of random length.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b0;
        cycles($urandom_range(1, 3));
        rst = 1'b1;
      end
      cycles(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ffinal
